// File: rtl/cosx_pkg.sv
// Shared definitions for the cos(x) sweep sequencer: default widths, timeout
// budget and the controller state encoding.
package cosx_pkg;

  localparam int XW_DEF      = 16;
  localparam int YW_DEF      = 8;
  localparam int CW_DEF      = 8;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_ISSUE = 3'd1;
  localparam logic [2:0] ENC_WAIT  = 3'd2;
  localparam logic [2:0] ENC_HOLD  = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ISSUE = ENC_ISSUE,
    ST_WAIT  = ENC_WAIT,
    ST_HOLD  = ENC_HOLD,
    ST_DONE  = ENC_DONE
  } state_e;

  // Counter width able to hold 0..timeout-1 (at least one bit).
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cosx_ready_watch.sv
// Rising-edge detector on the core ready level plus the per-point timeout
// counter used while waiting for the core.
module cosx_ready_watch
  import cosx_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic core_ready_i,
  output logic rise_o,
  output logic expired_o
);

  localparam int CNTW = cnt_width(TIMEOUT);

  logic            ready_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // ready_q resets high so a core idling with ready asserted is not a rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      ready_q <= core_ready_i;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  assign rise_o    = core_ready_i & ~ready_q;
  assign expired_o = en_i && (cnt_q == CNTW'(TIMEOUT - 1));

endmodule

// File: rtl/cosx_sweep_ctrl.sv
// Sweep sequencer for the cos(x) core: walks an arithmetic series of x values,
// starts the core per point and hands each result out on a valid/ready port.
module cosx_sweep_ctrl
  import cosx_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int YW      = YW_DEF,
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sweep_start_i,
  input  logic [XW-1:0] x_base_i,
  input  logic [XW-1:0] x_step_i,
  input  logic [CW-1:0] n_points_i,
  input  logic [YW-1:0] y_cfg_i,
  output logic [XW-1:0] core_x_o,
  output logic [YW-1:0] core_y_o,
  output logic          core_start_o,
  input  logic          core_ready_i,
  input  logic [XW-1:0] core_cosx_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [XW-1:0] res_x_o,
  output logic [XW-1:0] res_cos_o,
  output logic [CW-1:0] res_idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_err_o
);

  state_e state_q, state_d;

  logic [XW-1:0] step_q, step_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [XW-1:0] core_x_q, core_x_d;
  logic [YW-1:0] core_y_q, core_y_d;
  logic [XW-1:0] res_x_q, res_x_d;
  logic [XW-1:0] res_cos_q, res_cos_d;
  logic [CW-1:0] res_idx_q, res_idx_d;
  logic          timeout_err_q, timeout_err_d;

  logic wd_clr;
  logic wd_en;
  logic wd_rise;
  logic wd_expired;

  assign wd_clr = (state_q == ST_ISSUE);
  assign wd_en  = (state_q == ST_WAIT);

  cosx_ready_watch #(
    .TIMEOUT(TIMEOUT)
  ) u_ready_watch (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (wd_clr),
    .en_i        (wd_en),
    .core_ready_i(core_ready_i),
    .rise_o      (wd_rise),
    .expired_o   (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      core_x_q      <= '0;
      core_y_q      <= '0;
      res_x_q       <= '0;
      res_cos_q     <= '0;
      res_idx_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      core_x_q      <= core_x_d;
      core_y_q      <= core_y_d;
      res_x_q       <= res_x_d;
      res_cos_q     <= res_cos_d;
      res_idx_q     <= res_idx_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    n_d           = n_q;
    idx_d         = idx_q;
    core_x_d      = core_x_q;
    core_y_d      = core_y_q;
    res_x_d       = res_x_q;
    res_cos_d     = res_cos_q;
    res_idx_d     = res_idx_q;
    timeout_err_d = timeout_err_q;
    core_start_o  = 1'b0;
    res_valid_o   = 1'b0;
    done_o        = 1'b0;
    busy_o        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (sweep_start_i) begin
          step_d        = x_step_i;
          n_d           = n_points_i;
          core_y_d      = y_cfg_i;
          core_x_d      = x_base_i;
          idx_d         = '0;
          timeout_err_d = 1'b0;
          state_d       = (n_points_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_start_o = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A rise arriving on the final counted cycle still wins over the timeout.
        if (wd_rise) begin
          res_cos_d = core_cosx_i;
          res_x_d   = core_x_q;
          res_idx_d = idx_q;
          state_d   = ST_HOLD;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_HOLD: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          if (idx_q == n_q - CW'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + CW'(1);
            core_x_d = core_x_q + step_q;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign core_x_o      = core_x_q;
  assign core_y_o      = core_y_q;
  assign res_x_o       = res_x_q;
  assign res_cos_o     = res_cos_q;
  assign res_idx_o     = res_idx_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_cosx_sweep_ctrl.sv
// Self-checking bench for cosx_sweep_ctrl: behavioural core model, scoreboard
// of expected core_x / results, table of sweeps plus hand-written corner cases.
module tb_cosx_sweep_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        sweep_start;
  logic [15:0] x_base;
  logic [15:0] x_step;
  logic [7:0]  n_points;
  logic [7:0]  y_cfg;
  logic [15:0] core_x_o;
  logic [7:0]  core_y_o;
  logic        core_start_o;
  logic        core_ready;
  logic [15:0] core_cosx;
  logic        res_valid_o;
  logic        res_ready;
  logic [15:0] res_x_o;
  logic [15:0] res_cos_o;
  logic [7:0]  res_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_err_o;

  cosx_sweep_ctrl #(
    .XW(16), .YW(8), .CW(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sweep_start_i(sweep_start),
    .x_base_i     (x_base),
    .x_step_i     (x_step),
    .n_points_i   (n_points),
    .y_cfg_i      (y_cfg),
    .core_x_o     (core_x_o),
    .core_y_o     (core_y_o),
    .core_start_o (core_start_o),
    .core_ready_i (core_ready),
    .core_cosx_i  (core_cosx),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready),
    .res_x_o      (res_x_o),
    .res_cos_o    (res_cos_o),
    .res_idx_o    (res_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_err_o(timeout_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] cosv;
    logic [7:0]  idx;
  } res_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    logic [7:0]  n;
    logic [7:0]  y;
    int          delay;
  } vec_t;

  res_t        exp_q[$];
  logic [15:0] xs_q[$];
  logic [7:0]  cur_y;
  int          core_delay;
  int          starts_seen;
  int          dones_seen;
  int          valid_seen;
  int          s_starts0;
  int          s_dones0;
  int          pass_cnt;
  int          total_cnt;

  function automatic logic [15:0] cos_model(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Core model: drops ready on start, raises it with a result after core_delay
  // cycles; core_delay == 0 means the core never answers.
  initial begin : core_model
    int          cnt;
    logic [15:0] cx;
    cnt        = 0;
    cx         = '0;
    core_ready = 1'b1;
    core_cosx  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        core_ready = 1'b1;
        cnt        = 0;
      end else if (core_start_o) begin
        core_ready = 1'b0;
        cnt        = core_delay;
        cx         = core_x_o;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_ready = 1'b1;
          core_cosx  = cos_model(cx);
        end
      end
    end
  end

  // Monitor: core_x/core_y on each start, scoreboard pop on each handshake.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (core_start_o) begin
          starts_seen++;
          if (xs_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_core_start: core_x 0x%0h with no start expected at %0t", core_x_o, $time);
          end else begin
            check("core_x", {16'h0, core_x_o}, {16'h0, xs_q.pop_front()});
            check("core_y", {24'h0, core_y_o}, {24'h0, cur_y});
          end
        end
        if (res_valid_o) valid_seen++;
        if (res_valid_o && res_ready) begin
          $display("result idx=%0d x=0x%04h cos=0x%04h", res_idx_o, res_x_o, res_cos_o);
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_result: idx %0d with no result expected at %0t", res_idx_o, $time);
          end else begin
            e = exp_q.pop_front();
            check("res_x",   {16'h0, res_x_o},   {16'h0, e.x});
            check("res_cos", {16'h0, res_cos_o}, {16'h0, e.cosv});
            check("res_idx", {24'h0, res_idx_o}, {24'h0, e.idx});
          end
        end
        if (done_o) dones_seen++;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_core_x"},  {16'h0, core_x_o},  32'h0);
    check({tag, "_core_y"},  {24'h0, core_y_o},  32'h0);
    check({tag, "_res_x"},   {16'h0, res_x_o},   32'h0);
    check({tag, "_res_cos"}, {16'h0, res_cos_o}, 32'h0);
    check({tag, "_res_idx"}, {24'h0, res_idx_o}, 32'h0);
    check({tag, "_flags"},
          {26'h0, core_start_o, res_valid_o, busy_o, done_o, timeout_err_o, 1'b0}, 32'h0);
  endtask

  // Returns at the cycle after acceptance (ISSUE, or DONE for an empty sweep).
  task automatic start_sweep(input logic [15:0] base, input logic [15:0] step,
                             input logic [7:0] n, input logic [7:0] y,
                             input int delay, input bit push_all);
    logic [15:0] xv;
    core_delay = delay;
    cur_y      = y;
    s_starts0  = starts_seen;
    s_dones0   = dones_seen;
    if (push_all) begin
      for (int i = 0; i < int'(n); i++) begin
        xv = base + step * 16'(i);
        xs_q.push_back(xv);
        exp_q.push_back('{x: xv, cosv: cos_model(xv), idx: 8'(i)});
      end
    end
    @(negedge clk);
    sweep_start = 1'b1;
    x_base      = base;
    x_step      = step;
    n_points    = n;
    y_cfg       = y;
    @(negedge clk);
    sweep_start = 1'b0;
    #2;
    if (n != 8'd0) check("accept_core_start", {31'h0, core_start_o}, 32'h1);
    else           check("accept_done",       {31'h0, done_o},       32'h1);
    check("accept_busy", {31'h0, busy_o},        32'h1);
    check("accept_terr", {31'h0, timeout_err_o}, 32'h0);
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (!done_o && cyc < max_cyc) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (!done_o) begin
      total_cnt++;
      $display("FAIL %s_done_wait: done not seen within %0d cycles", tag, max_cyc);
    end
  endtask

  task automatic end_sweep(input string tag, input int n_starts);
    @(negedge clk);
    #2;
    check({tag, "_busy_after"}, {31'h0, busy_o}, 32'h0);
    check({tag, "_starts"}, 32'(starts_seen - s_starts0), 32'(n_starts));
    check({tag, "_dones"},  32'(dones_seen - s_dones0),   32'h1);
    check({tag, "_pending"}, 32'(exp_q.size() + xs_q.size()), 32'h0);
  endtask

  vec_t vecs[5];

  initial begin : main
    int cyc;
    int v0;
    pass_cnt    = 0;
    total_cnt   = 0;
    starts_seen = 0;
    dones_seen  = 0;
    valid_seen  = 0;
    core_delay  = 20;
    cur_y       = '0;
    rst_n       = 1'b0;
    sweep_start = 1'b0;
    x_base      = '0;
    x_step      = '0;
    n_points    = '0;
    y_cfg       = '0;
    res_ready   = 1'b1;

    vecs[0] = '{base: 16'h0180, step: 16'h0080, n: 8'd3, y: 8'hFF, delay: 20};
    vecs[1] = '{base: 16'h4321, step: 16'h0010, n: 8'd0, y: 8'h11, delay: 20};
    vecs[2] = '{base: 16'hFF80, step: 16'h0100, n: 8'd2, y: 8'h3C, delay: 20};
    vecs[3] = '{base: 16'h1000, step: 16'h0333, n: 8'd5, y: 8'hA5, delay: 1};
    vecs[4] = '{base: 16'h7FFF, step: 16'h0001, n: 8'd1, y: 8'h00, delay: 7};

    repeat (2) @(negedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("idle_busy", {31'h0, busy_o}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      start_sweep(vecs[v].base, vecs[v].step, vecs[v].n, vecs[v].y, vecs[v].delay, 1'b1);
      wait_done("table", 2000, cyc);
      end_sweep("table", int'(vecs[v].n));
    end

    // Backpressure, with an ignored sweep_start while busy.
    res_ready = 1'b0;
    start_sweep(16'h0180, 16'h0080, 8'd3, 8'hFF, 20, 1'b1);
    @(negedge clk);
    sweep_start = 1'b1;
    x_base      = 16'h1234;
    n_points    = 8'd9;
    y_cfg       = 8'h00;
    @(negedge clk);
    sweep_start = 1'b0;
    cyc = 0;
    while (!res_valid_o && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("bp_valid_seen", {31'h0, res_valid_o}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", {31'h0, res_valid_o}, 32'h1);
      check("bp_hold_x",   {16'h0, res_x_o},   32'h0180);
      check("bp_hold_cos", {16'h0, res_cos_o}, {16'h0, cos_model(16'h0180)});
      check("bp_no_start", 32'(starts_seen - s_starts0), 32'h1);
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    #2;
    check("bp_start_after_hs", {31'h0, core_start_o}, 32'h1);
    wait_done("bp", 2000, cyc);
    end_sweep("bp", 3);

    // Timeout: core never answers; only the first point's start is expected.
    core_delay = 0;
    xs_q.push_back(16'h0100);
    v0 = valid_seen;
    start_sweep(16'h0100, 16'h0010, 8'd2, 8'h55, 0, 1'b0);
    wait_done("to", 200, cyc);
    check("to_latency", 32'(cyc), 32'(TIMEOUT + 1));
    check("to_err_at_done", {31'h0, timeout_err_o}, 32'h1);
    end_sweep("to", 1);
    repeat (3) @(negedge clk);
    #2;
    check("to_err_sticky", {31'h0, timeout_err_o}, 32'h1);
    check("to_no_valid", 32'(valid_seen - v0), 32'h0);
    start_sweep(16'h0040, 16'h0004, 8'd1, 8'h66, 5, 1'b1);
    wait_done("to_clear", 500, cyc);
    end_sweep("to_clear", 1);

    // Reset during WAIT of point 1: asynchronous clear, no done pulse.
    start_sweep(16'h0200, 16'h0040, 8'd3, 8'h77, 20, 1'b1);
    cyc = 0;
    while ((starts_seen - s_starts0) < 2 && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("rst_point1_started", 32'(starts_seen - s_starts0), 32'h2);
    repeat (5) @(negedge clk);
    #3;
    check("rst_pre_busy", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    xs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("midrst_idle", {31'h0, busy_o}, 32'h0);
    check("midrst_no_done", 32'(dones_seen - s_dones0), 32'h0);
    start_sweep(16'h0300, 16'h0020, 8'd2, 8'h12, 4, 1'b1);
    wait_done("post_rst", 500, cyc);
    end_sweep("post_rst", 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
